// File: rtl/loba_seq_if.sv
// rtl/loba_seq_if.sv - operand/result handshake bundle for the loba_seq multiplier
interface loba_seq_if #(
  parameter int N = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   p;
  logic             busy;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/loba_seq.sv
// rtl/loba_seq.sv - sequential leading-one-bit approximate multiplier, one segment product per cycle
// Optional LOBA_SEQ_ZERO_BYPASS_EN: a zero operand skips the accumulate phase.
module loba_seq #(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic        clk,
  input  logic        rst,
  loba_seq_if.slave   s_if
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SPLIT, S_ACC, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic [1:0]       r_mode;
  logic [1:0]       r_cnt;
  logic [2*N-1:0]   r_acc;
  logic [K-1:0]     r_ah, r_al, r_bh, r_bl;
  logic [SW-1:0]    r_sah, r_sal, r_sbh, r_sbl;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_busy;
  logic             w_accept;
  logic [1:0]       w_last;
  logic [K-1:0]     w_ah, w_al, w_bh, w_bl;
  logic [SW-1:0]    w_sah, w_sal, w_sbh, w_sbl;
  logic [N-1:0]     w_ra, w_rb;
  logic [K-1:0]     w_ma, w_mb;
  logic [SW:0]      w_sh;
  logic [2*K-1:0]   w_prod;
  logic [2*N-1:0]   w_term;

  // Shift that places the leading one of x at bit K-1 of the segment; zero input gives zero.
  function automatic logic [SW-1:0] seg_shift(input logic [N-1:0] x);
    int idx;
    int sh;
    idx = 0;
    for (int i = 0; i < N; i++) begin
      if (x[i]) idx = i;
    end
    sh = (idx > K - 1) ? idx - (K - 1) : 0;
    return SW'(sh);
  endfunction

  assign w_sah = seg_shift(r_a);
  assign w_ah  = K'(r_a >> w_sah);
  assign w_ra  = r_a & ~(N'(w_ah) << w_sah);
  assign w_sal = seg_shift(w_ra);
  assign w_al  = K'(w_ra >> w_sal);

  assign w_sbh = seg_shift(r_b);
  assign w_bh  = K'(r_b >> w_sbh);
  assign w_rb  = r_b & ~(N'(w_bh) << w_sbh);
  assign w_sbl = seg_shift(w_rb);
  assign w_bl  = K'(w_rb >> w_sbl);

  // Counter bit 1 picks A's segment, bit 0 picks B's: HH, HL, LH, LL.
  assign w_ma   = r_cnt[1] ? r_al : r_ah;
  assign w_mb   = r_cnt[0] ? r_bl : r_bh;
  assign w_sh   = {1'b0, (r_cnt[1] ? r_sal : r_sah)} + {1'b0, (r_cnt[0] ? r_sbl : r_sbh)};
  assign w_prod = w_ma * w_mb;
  assign w_term = (2 * N)'(w_prod) << w_sh;

  assign w_last   = (r_mode == 2'd0) ? 2'd0 : ((r_mode == 2'd1) ? 2'd1 : 2'd3);
  assign w_accept = s_if.in_valid & w_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
        if (s_if.in_valid) w_state_nxt = S_SPLIT;
      end
      S_SPLIT: begin
`ifdef LOBA_SEQ_ZERO_BYPASS_EN
        w_state_nxt = ((r_a == '0) || (r_b == '0)) ? S_DONE : S_ACC;
`else
        w_state_nxt = S_ACC;
`endif
      end
      S_ACC: begin
        if (r_cnt == w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (s_if.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_mode <= '0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_ah   <= '0;
      r_al   <= '0;
      r_bh   <= '0;
      r_bl   <= '0;
      r_sah  <= '0;
      r_sal  <= '0;
      r_sbh  <= '0;
      r_sbl  <= '0;
    end else begin
      if (w_accept) begin
        r_a    <= s_if.a;
        r_b    <= s_if.b;
        r_mode <= s_if.mode;
      end
      if (r_state == S_SPLIT) begin
        r_ah  <= w_ah;
        r_al  <= w_al;
        r_bh  <= w_bh;
        r_bl  <= w_bl;
        r_sah <= w_sah;
        r_sal <= w_sal;
        r_sbh <= w_sbh;
        r_sbl <= w_sbl;
        r_acc <= '0;
        r_cnt <= '0;
      end
      if (r_state == S_ACC) begin
        r_acc <= r_acc + w_term;
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end

  assign s_if.in_ready  = w_in_ready;
  assign s_if.out_valid = w_out_valid;
  assign s_if.busy      = w_busy;
  assign s_if.p         = r_acc;
endmodule

// File: tb/tb_loba_seq.sv
// tb/tb_loba_seq.sv - directed self-checking bench for loba_seq (N=16, K=4)
module tb_loba_seq;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  loba_seq_if #(.N(16)) bus ();

  loba_seq #(.N(16), .K(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .s_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_txn(input logic [15:0] ta, input logic [15:0] tb_v, input logic [1:0] tm,
                         output logic [31:0] tp, output int tlat);
    @(negedge clk);
    bus.a = ta; bus.b = tb_v; bus.mode = tm; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tlat = -1;
    tp   = 32'hFFFF_FFFF;
    for (int w = 0; w < 20 && !bus.in_ready; w++) @(negedge clk);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0; bus.a = 16'hDEAD; bus.b = 16'hBEEF; bus.mode = 2'd0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        tlat = c;
        tp   = bus.p;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0; bus.mode = '0;
    #12;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.p !== 32'd0) begin n_fail++; $display("FAIL reset_p got %0d want 0", bus.p); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_modes();
    logic [31:0] exp_p [3] = '{32'd57600, 32'd61200, 32'd65025};
    int          exp_l [3] = '{3, 4, 6};
    logic [31:0] tp;
    int          tl;
    for (int m = 0; m < 3; m++) begin
      run_txn(16'h00FF, 16'h00FF, 2'(m), tp, tl);
      n_cmp++; if (tp !== exp_p[m]) begin n_fail++; $display("FAIL mode%0d_p got %0d want %0d", m, tp, exp_p[m]); end
      n_cmp++; if (tl !== exp_l[m]) begin n_fail++; $display("FAIL mode%0d_latency got %0d want %0d", m, tl, exp_l[m]); end
    end
  endtask

  task automatic test_exact();
    logic [31:0] tp;
    int          tl;
    run_txn(16'h8001, 16'h0003, 2'd3, tp, tl);
    n_cmp++; if (tp !== 32'd98307) begin n_fail++; $display("FAIL exact_p got %0d want 98307", tp); end
    n_cmp++; if (tl !== 6) begin n_fail++; $display("FAIL exact_latency got %0d want 6", tl); end
  endtask

  task automatic test_zero();
    logic [31:0] tp;
    int          tl;
    int          exp_l;
`ifdef LOBA_SEQ_ZERO_BYPASS_EN
    exp_l = 2;
`else
    exp_l = 6;
`endif
    run_txn(16'h0000, 16'hFFFF, 2'd2, tp, tl);
    n_cmp++; if (tp !== 32'd0) begin n_fail++; $display("FAIL zero_p got %0d want 0", tp); end
    n_cmp++; if (tl !== exp_l) begin n_fail++; $display("FAIL zero_latency got %0d want %0d", tl, exp_l); end
  endtask

  task automatic test_hold();
    int seen;
    seen = 0;
    @(negedge clk);
    bus.a = 16'h8001; bus.b = 16'h0003; bus.mode = 2'd3; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin seen = 1; break; end
    end
    n_cmp++; if (seen !== 1) begin n_fail++; $display("FAIL hold_reach_done got %0d want 1", seen); end
    for (int c = 0; c < 5; c++) begin
      bus.a = 16'(c * 16'h1111 + 1); bus.b = 16'hFFFF - 16'(c); bus.in_valid = c[0];
      @(negedge clk);
      n_cmp++; if (bus.p !== 32'd98307) begin n_fail++; $display("FAIL hold_p cyc%0d got %0d want 98307", c, bus.p); end
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_out_valid cyc%0d got %b want 1", c, bus.out_valid); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready cyc%0d got %b want 0", c, bus.in_ready); end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] tp;
    int          tl;
    int          stray;
    @(negedge clk);
    bus.a = 16'h00FF; bus.b = 16'h00FF; bus.mode = 2'd2; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got %b want 1", bus.busy); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.p !== 32'd0) begin n_fail++; $display("FAIL midrst_p got %0d want 0", bus.p); end
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) stray++;
    end
    n_cmp++; if (stray !== 0) begin n_fail++; $display("FAIL midrst_stray_out_valid got %0d want 0", stray); end
    run_txn(16'h00FF, 16'h00FF, 2'd1, tp, tl);
    n_cmp++; if (tp !== 32'd61200) begin n_fail++; $display("FAIL midrst_next_p got %0d want 61200", tp); end
    n_cmp++; if (tl !== 4) begin n_fail++; $display("FAIL midrst_next_latency got %0d want 4", tl); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [4] = '{16'h00FF, 16'h8001, 16'h1234, 16'hFFFF};
    logic [15:0] vb [4] = '{16'h00FF, 16'h0003, 16'h5678, 16'hFFFF};
    logic [31:0] vp [4] = '{32'd57600, 32'd98304, 32'd94371840, 32'd3774873600};
    int aidx, ridx, last_acc, acc_pend;
    aidx = 0; ridx = 0; last_acc = -1; acc_pend = 0;
    @(negedge clk);
    bus.mode = 2'd0; bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && ridx < 4; cyc++) begin
      if (acc_pend != 0) begin aidx++; acc_pend = 0; end
      if (aidx < 4) begin bus.a = va[aidx]; bus.b = vb[aidx]; bus.in_valid = 1'b1; end
      else bus.in_valid = 1'b0;
      #1;
      if (bus.out_valid && ridx < 4) begin
        n_cmp++; if (bus.p !== vp[ridx]) begin n_fail++; $display("FAIL b2b_p%0d got %0d want %0d", ridx, bus.p, vp[ridx]); end
        ridx++;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (last_acc >= 0) begin
          n_cmp++; if (cyc - last_acc !== 4) begin n_fail++; $display("FAIL b2b_interval got %0d want 4", cyc - last_acc); end
        end
        last_acc = cyc;
        acc_pend = 1;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    n_cmp++; if (ridx !== 4) begin n_fail++; $display("FAIL b2b_result_count got %0d want 4", ridx); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_modes();
    test_exact();
    test_zero();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
